freelist_mw: RTL and testbench

- Multi-way physical-register free list for the rename stage.
- Each cycle it hands up to ALLOC_W free physical registers to rename and accepts up to FREE_W released registers from commit.
- Implemented as a circular queue of PHYS_REGS entries with wrap-tagged head and tail pointers.
- Successor to the single-lane free list. Adds per-lane allocate and free, an occupancy count, overflow detection and optional branch checkpoint/restore.

---
 rtl/freelist_mw_if.sv | 23 ++
 rtl/freelist_mw.sv | 165 ++++++++++++++++
 tb/tb_freelist_mw.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/freelist_mw_if.sv
// freelist_mw_if: allocate/free lane bundle between rename, commit and the free list.
// master drives requests and releases; slave returns free tags.
interface freelist_mw_if #(
  parameter int PR_BITS = 6,
  parameter int ALLOC_W = 2,
  parameter int FREE_W  = 2
);
  logic [ALLOC_W-1:0]         alloc_req;
  logic [ALLOC_W-1:0]         alloc_valid;
  logic [ALLOC_W*PR_BITS-1:0] alloc_reg;
  logic [FREE_W-1:0]          free_en;
  logic [FREE_W*PR_BITS-1:0]  free_reg;

  modport master (
    output alloc_req, free_en, free_reg,
    input  alloc_valid, alloc_reg
  );

  modport slave (
    input  alloc_req, free_en, free_reg,
    output alloc_valid, alloc_reg
  );
endinterface

// File: rtl/freelist_mw.sv
// freelist_mw: multi-way physical register free list, circular queue with wrap-tagged pointers.
// Define FREELIST_CKPT_EN to build head-pointer checkpoint/restore storage.
module freelist_mw #(
  parameter int PHYS_REGS = 64,
  parameter int ARCH_REGS = 32,
  parameter int PR_BITS   = $clog2(PHYS_REGS),
  parameter int ALLOC_W   = 2,
  parameter int FREE_W    = 2,
  parameter int NUM_CKPT  = 4,
  localparam int CK_BITS  = (NUM_CKPT > 1) ? $clog2(NUM_CKPT) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  freelist_mw_if.slave       fl,
  output logic [PR_BITS:0]   free_count,
  output logic               overflow_err,
  input  logic               ckpt_save,
  input  logic [CK_BITS-1:0] ckpt_save_id,
  input  logic               ckpt_restore,
  input  logic [CK_BITS-1:0] ckpt_restore_id
);

  localparam int PW     = PR_BITS + 1;
  localparam int INIT_N = PHYS_REGS - ARCH_REGS;

  typedef logic [PR_BITS-1:0] tag_t;
  typedef logic [PW-1:0]      ptr_t;

  tag_t q [PHYS_REGS];
  ptr_t head;
  ptr_t tail;
  ptr_t count;
  ptr_t n_alloc;
  ptr_t n_free;
  ptr_t space;
  ptr_t head_nxt;
  ptr_t tail_nxt;
  logic restore_req;
  logic ovf_free;
  logic ovf_rst;

  logic [FREE_W-1:0] wr_en;
  tag_t              wr_idx [FREE_W];
  tag_t              wr_tag [FREE_W];

  logic [ALLOC_W-1:0]         valid_c;
  logic [ALLOC_W*PR_BITS-1:0] reg_c;

  assign count          = tail - head;
  assign free_count     = count;
  assign fl.alloc_valid = valid_c;
  assign fl.alloc_reg   = reg_c;

  always_comb begin
    valid_c = '0;
    reg_c   = '0;
    n_alloc = '0;
    for (int i = 0; i < ALLOC_W; i++) begin
      valid_c[i] = count > ptr_t'(i);
      if (valid_c[i]) begin
        reg_c[i*PR_BITS +: PR_BITS] =
          q[head[PR_BITS-1:0] + tag_t'(i)];
      end
      if (valid_c[i] && fl.alloc_req[i]) begin
        n_alloc = n_alloc + ptr_t'(1);
      end
    end
  end

`ifdef FREELIST_CKPT_EN
  ptr_t ckpt [NUM_CKPT];
  ptr_t rst_head;
  assign restore_req = ckpt_restore;
  assign rst_head    = ckpt[ckpt_restore_id];
`else
  logic ckpt_unused;
  assign restore_req = 1'b0;
  assign ckpt_unused = ^{ckpt_save, ckpt_save_id,
                         ckpt_restore, ckpt_restore_id};
`endif

  // Room counts this cycle's allocations unless a restore discards them.
  always_comb begin
    space = ptr_t'(PHYS_REGS) - count
          + (restore_req ? ptr_t'(0) : n_alloc);
    n_free   = '0;
    ovf_free = 1'b0;
    wr_en    = '0;
    for (int j = 0; j < FREE_W; j++) begin
      wr_idx[j] = tail[PR_BITS-1:0] + n_free[PR_BITS-1:0];
      wr_tag[j] = fl.free_reg[j*PR_BITS +: PR_BITS];
      if (fl.free_en[j] && wr_tag[j] != '0) begin
        if (n_free < space) begin
          wr_en[j] = 1'b1;
          n_free   = n_free + ptr_t'(1);
        end else begin
          ovf_free = 1'b1;
        end
      end
    end
  end

  assign tail_nxt = tail + n_free;

  always_comb begin
    head_nxt = head + n_alloc;
    ovf_rst  = 1'b0;
`ifdef FREELIST_CKPT_EN
    if (ckpt_restore) begin
      if (tail_nxt - rst_head > ptr_t'(PHYS_REGS)) begin
        head_nxt = head;
        ovf_rst  = 1'b1;
      end else begin
        head_nxt = rst_head;
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head         <= '0;
      tail         <= ptr_t'(INIT_N);
      overflow_err <= 1'b0;
      for (int i = 0; i < PHYS_REGS; i++) begin
        q[i] <= (i < INIT_N) ? tag_t'(ARCH_REGS + i) : '0;
      end
    end else if (flush) begin
      head         <= '0;
      tail         <= ptr_t'(INIT_N);
      overflow_err <= 1'b0;
      for (int i = 0; i < PHYS_REGS; i++) begin
        q[i] <= (i < INIT_N) ? tag_t'(ARCH_REGS + i) : '0;
      end
    end else begin
      head <= head_nxt;
      tail <= tail_nxt;
      for (int j = 0; j < FREE_W; j++) begin
        if (wr_en[j]) q[wr_idx[j]] <= wr_tag[j];
      end
      if (ovf_free || ovf_rst) overflow_err <= 1'b1;
    end
  end

`ifdef FREELIST_CKPT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_CKPT; k++) ckpt[k] <= '0;
    end else if (flush) begin
      for (int k = 0; k < NUM_CKPT; k++) ckpt[k] <= '0;
    end else if (ckpt_save && !ckpt_restore) begin
      ckpt[ckpt_save_id] <= head_nxt;
    end
  end
`endif

  logic [ALLOC_W:0] req_inc;
  assign req_inc = {1'b0, fl.alloc_req} + (ALLOC_W+1)'(1);

  // Requests must form a run from lane 0: req+1 shares no bits with req.
  assert property (@(posedge clk) disable iff (!rst_n)
    (({1'b0, fl.alloc_req} & req_inc) == '0));

endmodule

// File: tb/tb_freelist_mw.sv
// tb_freelist_mw: directed checks of allocate, free, wrap, overflow and flush.
// Checkpoint steps run only when FREELIST_CKPT_EN is defined.
module tb_freelist_mw;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       flush = 1'b0;
  logic       ckpt_save = 1'b0;
  logic       ckpt_restore = 1'b0;
  logic [1:0] ckpt_save_id = 2'd0;
  logic [1:0] ckpt_restore_id = 2'd0;
  logic [6:0] free_count;
  logic       overflow_err;
  logic [5:0] l0;
  logic [5:0] l1;

  int total = 0;
  int bad = 0;

  freelist_mw_if #(.PR_BITS(6), .ALLOC_W(2), .FREE_W(2)) fl ();

  freelist_mw dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .flush           (flush),
    .fl              (fl),
    .free_count      (free_count),
    .overflow_err    (overflow_err),
    .ckpt_save       (ckpt_save),
    .ckpt_save_id    (ckpt_save_id),
    .ckpt_restore    (ckpt_restore),
    .ckpt_restore_id (ckpt_restore_id)
  );

  always #5 clk = ~clk;

  assign l0 = fl.alloc_reg[5:0];
  assign l1 = fl.alloc_reg[11:6];

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setin(input logic [1:0] req,
                       input logic [1:0] fen,
                       input logic [5:0] t0,
                       input logic [5:0] t1);
    fl.alloc_req = req;
    fl.free_en   = fen;
    fl.free_reg  = {t1, t0};
  endtask

  task automatic state(input string tag,
                       input int cnt,
                       input int vld,
                       input int a0,
                       input int a1);
    chk({tag, ".count"}, 32'(free_count), 32'(cnt));
    chk({tag, ".valid"}, 32'(fl.alloc_valid), 32'(vld));
    chk({tag, ".lane0"}, 32'(l0), 32'(a0));
    chk({tag, ".lane1"}, 32'(l1), 32'(a1));
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  initial begin
    setin(2'b00, 2'b00, 6'd0, 6'd0);
    #12;
    state("reset", 32, 3, 32, 33);
    chk("reset.ovf", 32'(overflow_err), 0);
    rst_n = 1'b1;

    for (int c = 0; c < 16; c++) begin
      setin(2'b11, 2'b00, 6'd0, 6'd0);
      chk("drain.lane0", 32'(l0), 32'(32 + 2*c));
      chk("drain.lane1", 32'(l1), 32'(33 + 2*c));
      tick();
    end
    state("empty", 0, 0, 0, 0);
    tick();
    state("empty_req", 0, 0, 0, 0);

    setin(2'b00, 2'b11, 6'd5, 6'd0);
    chk("no_bypass.valid", 32'(fl.alloc_valid), 0);
    tick();
    setin(2'b00, 2'b00, 6'd0, 6'd0);
    state("free_tag0", 1, 1, 5, 0);

    setin(2'b00, 2'b11, 6'd11, 6'd12);
    tick();
    state("fill3", 3, 3, 5, 11);
    setin(2'b11, 2'b11, 6'd7, 6'd9);
    tick();
    state("alloc_free", 3, 3, 12, 7);
    setin(2'b11, 2'b00, 6'd0, 6'd0);
    tick();
    state("after_af", 1, 1, 9, 0);
    setin(2'b01, 2'b00, 6'd0, 6'd0);
    tick();
    state("single_lane", 0, 0, 0, 0);
    setin(2'b00, 2'b00, 6'd0, 6'd0);

    do_flush();
    state("flush1", 32, 3, 32, 33);
    for (int c = 0; c < 16; c++) begin
      setin(2'b00, 2'b11, 6'(1 + 2*c), 6'(2 + 2*c));
      tick();
    end
    state("full", 64, 3, 32, 33);
    chk("full.ovf", 32'(overflow_err), 0);
    for (int c = 0; c < 4; c++) begin
      setin(2'b00, 2'b11, 6'd40, 6'd41);
      tick();
    end
    chk("sat.count", 32'(free_count), 64);
    chk("sat.ovf", 32'(overflow_err), 1);
    setin(2'b11, 2'b01, 6'd50, 6'd0);
    tick();
    state("full_af", 63, 3, 34, 35);
    chk("sticky.ovf", 32'(overflow_err), 1);
    setin(2'b00, 2'b00, 6'd0, 6'd0);
    do_flush();
    state("flush2", 32, 3, 32, 33);
    chk("flush2.ovf", 32'(overflow_err), 0);

    setin(2'b11, 2'b00, 6'd0, 6'd0);
    for (int c = 0; c < 16; c++) tick();
    chk("wrap.empty", 32'(free_count), 0);
    for (int c = 0; c < 20; c++) begin
      setin(2'b00, 2'b11, 6'(1 + 2*c), 6'(2 + 2*c));
      tick();
    end
    chk("wrap.count", 32'(free_count), 40);
    chk("wrap.ovf", 32'(overflow_err), 0);
    for (int c = 0; c < 20; c++) begin
      setin(2'b11, 2'b00, 6'd0, 6'd0);
      chk("wrap.lane0", 32'(l0), 32'(1 + 2*c));
      chk("wrap.lane1", 32'(l1), 32'(2 + 2*c));
      tick();
    end
    setin(2'b00, 2'b00, 6'd0, 6'd0);
    state("wrap.end", 0, 0, 0, 0);

    do_flush();
`ifdef FREELIST_CKPT_EN
    setin(2'b11, 2'b00, 6'd0, 6'd0);
    tick();
    setin(2'b00, 2'b00, 6'd0, 6'd0);
    ckpt_save    = 1'b1;
    ckpt_save_id = 2'd1;
    tick();
    ckpt_save = 1'b0;
    state("ckpt.saved", 30, 3, 34, 35);
    setin(2'b11, 2'b00, 6'd0, 6'd0);
    tick();
    chk("ckpt.a2.lane0", 32'(l0), 36);
    chk("ckpt.a2.lane1", 32'(l1), 37);
    tick();
    setin(2'b00, 2'b00, 6'd0, 6'd0);
    state("ckpt.a4", 26, 3, 38, 39);
    ckpt_restore    = 1'b1;
    ckpt_restore_id = 2'd1;
    tick();
    ckpt_restore = 1'b0;
    state("ckpt.restored", 30, 3, 34, 35);
    chk("ckpt.ovf", 32'(overflow_err), 0);
`else
    setin(2'b11, 2'b00, 6'd0, 6'd0);
    ckpt_restore    = 1'b1;
    ckpt_restore_id = 2'd1;
    ckpt_save       = 1'b1;
    tick();
    ckpt_restore = 1'b0;
    ckpt_save    = 1'b0;
    setin(2'b00, 2'b00, 6'd0, 6'd0);
    state("ckpt.ignored", 30, 3, 34, 35);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
